// File: rtl/i2c_write_engine.sv
// Write-only I2C master: START, N_BYTES bytes MSB-first each with an ACK slot, then STOP.
// Bus outputs are registered from the current state, so the pins trail the FSM by one clk_i2c cycle.
`timescale 1ns/1ps
module i2c_write_engine #(
  parameter int N_BYTES = 3
) (
  input  logic                   clk_i2c,
  input  logic                   reset_n,
  input  logic [8*N_BYTES-1:0]   i2c_data,
  input  logic                   go,
  output logic                   done,
  output logic                   busy,
  output logic [N_BYTES-1:0]     ack,
  output logic                   i2c_sclk,
  inout  wire                    i2c_sdat
);

  localparam int BW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, START, BIT, ACKS, STOP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic [2:0]             bit_q, bit_d;
  logic [BW-1:0]          byte_q, byte_d;
  logic [8*N_BYTES-1:0]   shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [N_BYTES-1:0]     ack_q, ack_d;
  logic                   scl_q, scl_d;
  logic                   sda_low_q, sda_low_d;
  logic                   ack_strobe_q, ack_strobe_d;
  logic [BW-1:0]          ack_idx_q, ack_idx_d;
  logic                   accept;

  always_ff @(posedge clk_i2c) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      bit_q        <= 3'd7;
      byte_q       <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      scl_q        <= 1'b1;
      sda_low_q    <= 1'b0;
      ack_strobe_q <= 1'b0;
      ack_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      scl_q        <= scl_d;
      sda_low_q    <= sda_low_d;
      ack_strobe_q <= ack_strobe_d;
      ack_idx_q    <= ack_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && !done_q) begin
          accept  = 1'b1;
          shift_d = i2c_data;
          phase_d = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (phase_q == 2'd1) begin
          state_d = BIT;
          phase_d = 2'd0;
          bit_d   = 3'd7;
          byte_d  = '0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      BIT: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = ACKS;
        end
      end
      ACKS: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (byte_q == BW'(N_BYTES - 1)) begin
            state_d = STOP;
          end else begin
            state_d = BIT;
            byte_d  = byte_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (phase_q == 2'd2) begin
          state_d = DONE;
          phase_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      DONE: begin
        if (done_q && !go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // done rises one cycle after entering DONE and falls on the same edge that returns to IDLE.
  always_comb begin
    done_d = done_q;
    busy_d = busy_q;
    if (state_q == DONE && !done_q) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end else if (done_q && !go) begin
      done_d = 1'b0;
    end
    if (accept) busy_d = 1'b1;
  end

  // The ACK bit is sampled as the registered SCL leaves the last high quarter of the ACK slot.
  always_comb begin
    ack_d        = ack_q;
    ack_strobe_d = (state_q == ACKS) && (phase_q == 2'd3);
    ack_idx_d    = byte_q;
    if (accept) begin
      ack_d = '0;
    end else if (ack_strobe_q) begin
      for (int i = 0; i < N_BYTES; i++) begin
        if (ack_idx_q == BW'(N_BYTES - 1 - i)) ack_d[i] = i2c_sdat;
      end
    end
  end

  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_q)
      START: begin
        scl_d     = (phase_q == 2'd0);
        sda_low_d = 1'b1;
      end
      BIT: begin
        scl_d     = phase_q[1];
        sda_low_d = ~shift_q[8*N_BYTES-1];
      end
      ACKS: begin
        scl_d     = phase_q[1];
        sda_low_d = 1'b0;
      end
      STOP: begin
        scl_d     = (phase_q != 2'd0);
        sda_low_d = (phase_q != 2'd2);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
  assign i2c_sclk = scl_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: pulled-up SDA, ACK/NACK-driving slave, bus decoder and
// a transfer-level reference model (expected bytes, ACK slots, done latency).
`timescale 1ns/1ps
module tb_i2c_write_engine;

  localparam int NB  = 3;
  localparam int LAT = 6 + 36 * NB;

  logic            clkI2c = 1'b0;
  logic            resetN;
  logic            go;
  logic [8*NB-1:0] i2cData;
  logic            done;
  logic            busy;
  logic [NB-1:0]   ack;
  logic            i2cSclk;
  wire             i2cSdat;

  logic            slaveDrive = 1'b0;
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              kEdge = 0;

  logic            monOn = 1'b0;
  logic            sclPrev = 1'b1;
  logic            sdaPrev = 1'b1;
  logic            sclNow;
  logic            sdaNow;
  logic            inXfer = 1'b0;
  int              bitCnt = 0;
  int              startCnt = 0;
  int              stopCnt = 0;
  logic [9*NB-1:0] busBits = '0;
  logic [NB-1:0]   nackMask = '0;

  assign i2cSdat = slaveDrive ? 1'b0 : 1'bz;
  pullup (i2cSdat);

  i2c_write_engine #(.N_BYTES(NB)) dut (
    .clk_i2c  (clkI2c),
    .reset_n  (resetN),
    .i2c_data (i2cData),
    .go       (go),
    .done     (done),
    .busy     (busy),
    .ack      (ack),
    .i2c_sclk (i2cSclk),
    .i2c_sdat (i2cSdat)
  );

  always #50 clkI2c = ~clkI2c;

  always @(posedge clkI2c) cyc <= cyc + 1;

  // Bus observer and slave: any SDA edge with SCL held high is a START (fall) or STOP (rise),
  // so a spurious change shows up as an extra START/STOP in the counts.
  always begin
    @(posedge clkI2c);
    #20;
    if (monOn) begin
      sclNow = i2cSclk;
      sdaNow = i2cSdat;
      if (sclNow && sclPrev && (sdaNow !== sdaPrev)) begin
        if (sdaNow === 1'b0) begin
          startCnt++;
          inXfer = 1'b1;
          bitCnt = 0;
        end else begin
          stopCnt++;
          inXfer = 1'b0;
        end
      end else if (sclNow && !sclPrev && inXfer) begin
        if (bitCnt < 9 * NB) busBits[9*NB-1-bitCnt] = sdaNow;
        bitCnt++;
      end else if (!sclNow && sclPrev) begin
        if (inXfer && (bitCnt % 9 == 8) && (bitCnt < 9 * NB))
          slaveDrive = (nackMask[NB-1-bitCnt/9] == 1'b0);
        else
          slaveDrive = 1'b0;
      end
      sclPrev = sclNow;
      sdaPrev = sdaNow;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*NB-1:0] expectBits(input logic [8*NB-1:0] d, input logic [NB-1:0] n);
    logic [9*NB-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) r[9*NB-1-9*b -: 9] = {d[8*NB-1-8*b -: 8], n[NB-1-b]};
    return r;
  endfunction

  // Raises go at a falling edge; the next rising edge (kEdge) accepts it. i2cData is then scrambled.
  task automatic applyStimulus(input logic [8*NB-1:0] data, input logic [NB-1:0] nack);
    @(negedge clkI2c);
    startCnt = 0;
    stopCnt  = 0;
    bitCnt   = 0;
    inXfer   = 1'b0;
    busBits  = '0;
    nackMask = nack;
    i2cData  = data;
    go       = 1'b1;
    kEdge    = cyc + 1;
    @(negedge clkI2c);
    i2cData  = $urandom;
  endtask

  task automatic waitDone(input int budget, output int doneCyc);
    doneCyc = -1;
    for (int n = 0; n < budget; n++) begin
      if (done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
      @(negedge clkI2c);
    end
  endtask

  task automatic waitCycle(input int target);
    for (int n = 0; n < 400 && cyc < target; n++) @(negedge clkI2c);
  endtask

  task automatic checkTransfer(input string tag, input logic [8*NB-1:0] data,
                               input logic [NB-1:0] nack, input int doneCyc);
    checkOutput({tag, "_latency"}, doneCyc, kEdge + LAT);
    checkOutput({tag, "_ack"}, ack, nack);
    checkOutput({tag, "_busbits"}, busBits, expectBits(data, nack));
    checkOutput({tag, "_starts"}, startCnt, 1);
    checkOutput({tag, "_stops"}, stopCnt, 1);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic releaseGo(input string tag);
    go = 1'b0;
    @(negedge clkI2c);
    checkOutput({tag, "_doneclr"}, done, 0);
    @(negedge clkI2c);
  endtask

  initial begin
    int              dc;
    logic [8*NB-1:0] d;
    logic [NB-1:0]   n;

    resetN  = 1'b0;
    go      = 1'b0;
    i2cData = '0;
    repeat (3) @(negedge clkI2c);
    checkOutput("rst_scl", i2cSclk, 1);
    checkOutput("rst_sda", i2cSdat, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ack", ack, 0);
    resetN = 1'b1;
    monOn  = 1'b1;
    repeat (2) @(negedge clkI2c);

    $display("[TB] T1 nominal transfer");
    applyStimulus(24'h341E00, 3'b000);
    checkOutput("t1_busy_accept", busy, 1);
    waitDone(300, dc);
    checkTransfer("t1", 24'h341E00, 3'b000, dc);
    releaseGo("t1");

    $display("[TB] T2 NACK on byte1");
    d = $urandom;
    applyStimulus(d, 3'b010);
    waitDone(300, dc);
    checkTransfer("t2", d, 3'b010, dc);
    releaseGo("t2");

    $display("[TB] T3 go dropped mid-transfer");
    d = $urandom;
    applyStimulus(d, 3'b001);
    waitCycle(kEdge + 20);
    go = 1'b0;
    waitDone(300, dc);
    checkTransfer("t3", d, 3'b001, dc);
    @(negedge clkI2c);
    checkOutput("t3_done_one_cycle", done, 0);
    repeat (2) @(negedge clkI2c);

    $display("[TB] T4 reset mid-transfer");
    d = $urandom;
    applyStimulus(d, 3'b100);
    waitCycle(kEdge + 45);
    checkOutput("t4_ack_before_reset", ack, 3'b100);
    waitCycle(kEdge + 49);
    resetN = 1'b0;
    @(negedge clkI2c);
    checkOutput("t4_scl", i2cSclk, 1);
    checkOutput("t4_sda", i2cSdat, 1);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_ack", ack, 0);
    go     = 1'b0;
    resetN = 1'b1;
    repeat (3) @(negedge clkI2c);
    d = $urandom;
    applyStimulus(d, 3'b000);
    waitDone(300, dc);
    checkTransfer("t4_restart", d, 3'b000, dc);
    releaseGo("t4_restart");

    $display("[TB] T5 go held past done");
    d = $urandom;
    applyStimulus(d, 3'b011);
    waitDone(300, dc);
    checkTransfer("t5", d, 3'b011, dc);
    repeat (200) @(negedge clkI2c);
    checkOutput("t5_starts_held", startCnt, 1);
    checkOutput("t5_done_held", done, 1);
    checkOutput("t5_busy_held", busy, 0);
    releaseGo("t5");
    d = $urandom;
    applyStimulus(d, 3'b000);
    waitDone(300, dc);
    checkTransfer("t5_second", d, 3'b000, dc);
    releaseGo("t5_second");

    $display("[TB] random transfers");
    for (int r = 0; r < 4; r++) begin
      d = $urandom;
      n = NB'($urandom_range(0, (1 << NB) - 1));
      applyStimulus(d, n);
      waitDone(300, dc);
      checkTransfer($sformatf("rand%0d", r), d, n, dc);
      releaseGo($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
